// File: rtl/lc3b_types.sv
// Shared LC-3b types: cache-line and word types plus the arbiter state encoding.
package lc3b_types;

  typedef logic [127:0] lc3b_data;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } lc3b_arb_state;

  // last_grant encoding: which requester finished most recently
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam lc3b_word COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     inc,
  output lc3b_word count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// Handshake: a requester raises read/write with address/wdata and holds them stable
// until its resp pulses; resp is the pmem_resp of the granted cycle, passed through.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = $bits(lc3b_data)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output lc3b_word              i_grant_count,
  output lc3b_word              d_grant_count,
  output lc3b_arb_state         arb_state
);

  lc3b_arb_state state, next_state;
  logic          last_grant;
  logic          i_req, d_req;
  logic          i_done, d_done;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  assign i_done = (state == ARB_SERVE_I) && pmem_resp;
  assign d_done = (state == ARB_SERVE_D) && pmem_resp;

  assign arb_state = state;

  // A contested IDLE cycle goes to whoever did not finish last.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (i_req && d_req) begin
          next_state = (last_grant == GRANT_I) ? ARB_SERVE_D : ARB_SERVE_I;
        end else if (i_req) begin
          next_state = ARB_SERVE_I;
        end else if (d_req) begin
          next_state = ARB_SERVE_D;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_I;
    end else begin
      state <= next_state;
      if (i_done) begin
        last_grant <= GRANT_I;
      end else if (d_done) begin
        last_grant <= GRANT_D;
      end
    end
  end

  // Fill data fans out to both caches; only the resp lines are qualified.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state)
      ARB_SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      ARB_SERVE_D: begin
        // A simultaneous read+write from the D-cache is a writeback only.
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

  sat_counter16 u_i_count (
    .clk   (clk),
    .reset (reset),
    .inc   (i_done),
    .count (i_grant_count)
  );

  sat_counter16 u_d_count (
    .clk   (clk),
    .reset (reset),
    .inc   (d_done),
    .count (d_grant_count)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a transaction-level ownership model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_cache_arbiter;
  import lc3b_types::*;

  logic          clk;
  logic          reset;
  logic          i_pmem_read;
  logic [15:0]   i_pmem_address;
  logic [127:0]  i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [15:0]   d_pmem_address;
  logic [127:0]  d_pmem_wdata;
  logic [127:0]  d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [127:0]  pmem_wdata;
  logic [127:0]  pmem_rdata;
  logic          pmem_resp;
  lc3b_word      i_grant_count;
  lc3b_word      d_grant_count;
  lc3b_arb_state arb_state;
  logic          preload_d;

  int checks;
  int failures;

  cache_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .i_grant_count  (i_grant_count),
    .d_grant_count  (d_grant_count),
    .arb_state      (arb_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  // owner: 0 = nobody holds memory, 1 = I-cache, 2 = D-cache
  int m_owner;
  int m_last;   // 0 = I finished last, 1 = D finished last
  int m_cnt_i;
  int m_cnt_d;

  always @(posedge clk or posedge reset or posedge preload_d) begin
    if (reset) begin
      m_owner = 0;
      m_last  = 0;
      m_cnt_i = 0;
      m_cnt_d = 0;
    end else if (preload_d) begin
      m_cnt_d = 65534;
    end else begin
      if (m_owner == 0) begin
        if (i_pmem_read && (d_pmem_read || d_pmem_write)) m_owner = (m_last == 0) ? 2 : 1;
        else if (i_pmem_read) m_owner = 1;
        else if (d_pmem_read || d_pmem_write) m_owner = 2;
      end else if (pmem_resp) begin
        if (m_owner == 1) begin
          m_last = 0;
          if (m_cnt_i < 65535) m_cnt_i = m_cnt_i + 1;
        end else begin
          m_last = 1;
          if (m_cnt_d < 65535) m_cnt_d = m_cnt_d + 1;
        end
        m_owner = 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [15:0]   e_addr;
    logic [127:0]  e_wd;
    lc3b_arb_state e_st;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
    e_addr = '0; e_wd = '0; e_st = ARB_IDLE;
    if (m_owner == 1) begin
      e_st = ARB_SERVE_I; e_rd = i_pmem_read; e_addr = i_pmem_address; e_ir = pmem_resp;
    end else if (m_owner == 2) begin
      e_st = ARB_SERVE_D; e_wr = d_pmem_write; e_rd = d_pmem_read && !d_pmem_write;
      e_addr = d_pmem_address; e_wd = d_pmem_wdata; e_dr = pmem_resp;
    end
    check("cyc_state", 128'(arb_state), 128'(e_st));
    check("cyc_pmem_read", 128'(pmem_read), 128'(e_rd));
    check("cyc_pmem_write", 128'(pmem_write), 128'(e_wr));
    check("cyc_pmem_address", 128'(pmem_address), 128'(e_addr));
    check("cyc_pmem_wdata", pmem_wdata, e_wd);
    check("cyc_i_resp", 128'(i_pmem_resp), 128'(e_ir));
    check("cyc_d_resp", 128'(d_pmem_resp), 128'(e_dr));
    check("cyc_i_rdata", i_pmem_rdata, pmem_rdata);
    check("cyc_d_rdata", d_pmem_rdata, pmem_rdata);
    check("cyc_i_count", 128'(i_grant_count), 128'(m_cnt_i));
    check("cyc_d_count", 128'(d_grant_count), 128'(m_cnt_d));
  endtask

  // ---------------- drivers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic do_d(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [127:0] wd, input int lat);
    d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = addr; d_pmem_wdata = wd;
    step(1);
    if (lat > 1) step(lat - 1);
    pmem_resp = 1'b1;
    step(1);
    pmem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] WB_LINE = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  initial begin
    checks = 0; failures = 0; preload_d = 1'b0;
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100; pmem_resp = 1'b0;
    step(2);
    reset = 1'b0;

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // reset state
    check("rst_state", 128'(arb_state), 128'(ARB_IDLE));
    check("rst_i_count", 128'(i_grant_count), 128'h0);
    check("rst_d_count", 128'(d_grant_count), 128'h0);
    check("rst_pmem_read", 128'(pmem_read), 128'h0);

    // single I read, resp on the third serve cycle
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    step(1);
    check("i1_read_c1", 128'(pmem_read), 128'h1);
    check("i1_addr_c1", 128'(pmem_address), 128'h1230);
    check("i1_resp_c1", 128'(i_pmem_resp), 128'h0);
    step(1);
    check("i1_read_c2", 128'(pmem_read), 128'h1);
    step(1);
    pmem_resp = 1'b1;
    #1;
    check("i1_resp_c3", 128'(i_pmem_resp), 128'h1);
    check("i1_dresp_c3", 128'(d_pmem_resp), 128'h0);
    step(1);
    i_pmem_read = 1'b0; i_pmem_address = '0; pmem_resp = 1'b0;
    #1;
    check("i1_resp_after", 128'(i_pmem_resp), 128'h0);
    check("i1_count", 128'(i_grant_count), 128'h1);
    check("i1_idle", 128'(arb_state), 128'(ARB_IDLE));

    // D writeback
    d_pmem_write = 1'b1; d_pmem_address = 16'h4440; d_pmem_wdata = WB_LINE;
    step(1);
    check("dw_write", 128'(pmem_write), 128'h1);
    check("dw_read", 128'(pmem_read), 128'h0);
    check("dw_addr", 128'(pmem_address), 128'h4440);
    check("dw_wdata", pmem_wdata, WB_LINE);
    check("dw_resp_pre", 128'(d_pmem_resp), 128'h0);
    pmem_resp = 1'b1;
    #1;
    check("dw_resp", 128'(d_pmem_resp), 128'h1);
    step(1);
    d_pmem_write = 1'b0; pmem_resp = 1'b0;
    #1;
    check("dw_resp_after", 128'(d_pmem_resp), 128'h0);
    check("dw_count", 128'(d_grant_count), 128'h1);

    // pmem_resp while idle is ignored
    pmem_resp = 1'b1;
    #1;
    check("idle_i_resp", 128'(i_pmem_resp), 128'h0);
    check("idle_d_resp", 128'(d_pmem_resp), 128'h0);
    step(2);
    pmem_resp = 1'b0;
    check("idle_i_count", 128'(i_grant_count), 128'h1);
    check("idle_d_count", 128'(d_grant_count), 128'h1);

    // simultaneous requests after reset: D first, one dead cycle, then I
    apply_reset();
    check("rr_rst_count", 128'(d_grant_count), 128'h0);
    i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
    d_pmem_write = 1'b1; d_pmem_address = 16'h0200; d_pmem_wdata = 128'h55;
    step(1);
    check("rr_first_d", 128'(arb_state), 128'(ARB_SERVE_D));
    check("rr_first_write", 128'(pmem_write), 128'h1);
    pmem_resp = 1'b1;
    #1;
    check("rr_i_held", 128'(i_pmem_resp), 128'h0);
    step(1);
    d_pmem_write = 1'b0; pmem_resp = 1'b0;
    #1;
    check("rr_dead_cycle", 128'(arb_state), 128'(ARB_IDLE));
    step(1);
    check("rr_then_i", 128'(arb_state), 128'(ARB_SERVE_I));
    check("rr_i_addr", 128'(pmem_address), 128'h0100);
    pmem_resp = 1'b1;
    step(1);
    i_pmem_read = 1'b0; pmem_resp = 1'b0;
    #1;
    check("rr_i_count", 128'(i_grant_count), 128'h1);
    check("rr_d_count", 128'(d_grant_count), 128'h1);

    // reset in the middle of a D fill
    d_pmem_read = 1'b1; d_pmem_address = 16'h2220;
    step(1);
    check("mr_serving", 128'(arb_state), 128'(ARB_SERVE_D));
    #2;
    reset = 1'b1;
    #1;
    check("mr_read_zero", 128'(pmem_read), 128'h0);
    check("mr_addr_zero", 128'(pmem_address), 128'h0);
    check("mr_d_resp", 128'(d_pmem_resp), 128'h0);
    check("mr_state", 128'(arb_state), 128'(ARB_IDLE));
    check("mr_count", 128'(d_grant_count), 128'h0);
    d_pmem_read = 1'b0;
    step(1);
    reset = 1'b0; pmem_resp = 1'b1;
    #1;
    check("mr_late_resp", 128'(d_pmem_resp), 128'h0);
    step(1);
    pmem_resp = 1'b0;
    check("mr_late_count", 128'(d_grant_count), 128'h0);

    // saturation: preload the D count just below the top
    force dut.u_d_count.count = 16'hFFFE;
    preload_d = 1'b1;
    #1;
    release dut.u_d_count.count;
    preload_d = 1'b0;
    step(1);
    check("sat_preload", 128'(d_grant_count), 128'hFFFE);
    do_d(1'b1, 1'b1, 16'h3300, 128'hA5A5, 1);
    check("sat_first", 128'(d_grant_count), 128'hFFFF);
    do_d(1'b1, 1'b0, 16'h3310, 128'h0, 2);
    do_d(1'b0, 1'b1, 16'h3320, 128'h5A5A, 1);
    #1;
    check("sat_hold", 128'(d_grant_count), 128'hFFFF);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, physical byte-address width.
REQ-002 Parameter LINE_WIDTH, default 128, cache-line width (matches lc3b_data).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_pmem_read  input  1  I-cache line-fill request.
REQ-006 i_pmem_address  input  ADDR_WIDTH  I-cache line address.
REQ-007 i_pmem_rdata  output  LINE_WIDTH  fill data to I-cache.
REQ-008 i_pmem_resp  output  1  I-cache transaction done.
REQ-009 d_pmem_read  input  1  D-cache line-fill request.
REQ-010 d_pmem_write  input  1  D-cache writeback request.
REQ-011 d_pmem_address  input  ADDR_WIDTH  D-cache line address.
REQ-012 d_pmem_wdata  input  LINE_WIDTH  writeback line.
REQ-013 d_pmem_rdata  output  LINE_WIDTH  fill data to D-cache.
REQ-014 d_pmem_resp  output  1  D-cache transaction done.
REQ-015 pmem_read, pmem_write  output  1 each  request to the shared L2/physical memory.
REQ-016 pmem_address  output  ADDR_WIDTH; pmem_wdata  output  LINE_WIDTH; pmem_rdata  input  LINE_WIDTH; pmem_resp  input  1.
REQ-017 i_grant_count, d_grant_count  output  16  saturating count of completed grants per requester.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-019 In IDLE with only one requester active, the FSM SHALL move to that requester's SERVE state on the next edge.
REQ-020 In IDLE with both active, the FSM SHALL grant the requester not held in the 1-bit last_grant register (round-robin).
REQ-021 A D request SHALL be defined as d_pmem_read OR d_pmem_write; if both are high, the arbiter SHALL forward it as a write only.
REQ-022 In SERVE_x, pmem_read/pmem_write/pmem_address/pmem_wdata SHALL be driven combinationally from the granted requester's inputs; in IDLE all pmem_* outputs SHALL be 0.
REQ-023 pmem_rdata SHALL be routed to both i_pmem_rdata and d_pmem_rdata unconditionally; only the resp lines are qualified.
REQ-024 In SERVE_x, pmem_resp SHALL be passed combinationally to x's resp output, in the same cycle; the other resp output SHALL stay 0.
REQ-025 On an edge with pmem_resp=1 in SERVE_x, the FSM SHALL return to IDLE, set last_grant=x, and increment x's grant count.
REQ-026 Minimum grant-to-grant turnaround SHALL be one IDLE cycle; back-to-back requests SHALL therefore see one dead cycle.
REQ-027 pmem_resp in IDLE SHALL be ignored: no resp forwarded, no count change.
REQ-028 Requesters SHALL hold request, address, and wdata stable until their resp; the arbiter SHALL NOT latch them.
REQ-029 A granted request SHALL NOT be preempted; the other requester waits, with its resp held at 0.
REQ-030 Grant counts SHALL saturate at 16'hFFFF and not wrap.

Reset
REQ-031 While reset is high, the arbiter SHALL immediately (asynchronously) clear: FSM to IDLE, last_grant to I, and both counts to 0; all pmem_* and resp outputs read 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no resp issued; a pmem_resp arriving afterwards falls under REQ-027.

Structure
REQ-033 lc3b_data and lc3b_word SHALL come from the shared lc3b_types package.
REQ-034 The arbiter state enum (lc3b_arb_state) SHALL be added to lc3b_types.
REQ-035 The saturating counter SHALL be one sub-module, sat_counter16, instantiated twice.

Verification
REQ-036 Single I read, addr 16'h1230, pmem_resp after 3 cycles:
- pmem_read=1 and pmem_address=16'h1230 for those cycles;
- i_pmem_resp=1 in the resp cycle only;
- i_grant_count=1.
REQ-037 I read and D write asserted in the same cycle after reset:
- D is served first (last_grant=I);
- then one IDLE cycle;
- then I is served;
- both counts=1.
REQ-038 D write, wdata 128'hDEAD...BEEF, addr 16'h4440:
- pmem_write=1 with matching data and address;
- pmem_read=0;
- d_pmem_resp pulses once.
REQ-039 pmem_resp=1 while in IDLE:
- both resp outputs remain 0;
- counts unchanged.
REQ-040 Reset asserted during SERVE_D, before pmem_resp:
- outputs go 0 with no clock edge;
- state returns to IDLE;
- no d_pmem_resp issued.
REQ-041 Force d_grant_count to 16'hFFFE, then complete 3 D transactions:
- count reads 16'hFFFF and stays there.
